// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM state encoding and datapath width for the sequenced ALU.
package alu_pkg;
    localparam int DATA_W = 32;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b110;
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
endpackage

// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: request/result bundle of the sequenced ALU.
//   valid_i/ready_o request handshake, data1_i/data2_i operands, ALUCtrl_i op code,
//   valid_o/data_o result pulse and register, stall_o pipeline freeze request.
//   slave = the ALU block, master = the pipeline driving it.
interface alu_mul_seq_if;
    import alu_pkg::*;
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data1_i;
    logic [DATA_W-1:0] data2_i;
    logic [2:0]        ALUCtrl_i;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic              stall_o;
    modport slave  (input valid_i, data1_i, data2_i, ALUCtrl_i, output ready_o, valid_o, data_o, stall_o);
    modport master (output valid_i, data1_i, data2_i, ALUCtrl_i, input ready_o, valid_o, data_o, stall_o);
endinterface

// File: rtl/alu_mul_step.sv
// alu_mul_step: one shift-add multiply iteration, acc_next = acc + mcand * slice (mod 2^32).
//   acc, mcand in; slice = low BITS_PER_CYCLE multiplier bits in; acc_next out. Purely combinational.
module alu_mul_step
    import alu_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [DATA_W-1:0]         acc,
    input  logic [DATA_W-1:0]         mcand,
    input  logic [BITS_PER_CYCLE-1:0] slice,
    output logic [DATA_W-1:0]         acc_next
);
    assign acc_next = acc + mcand * {{(DATA_W-BITS_PER_CYCLE){1'b0}}, slice};
endmodule

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: EX-stage ALU with single-cycle logic/add/sub and an iterative shift-add MUL.
//   clk_i clock, rst_i async active-high reset, bus (alu_mul_seq_if.slave) request/result bundle.
//   Optional ALU_MUL_EARLY_EXIT_EN: finish MUL as soon as the remaining multiplier bits are zero.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    alu_mul_seq_if.slave bus
);
    localparam int MUL_ITERS = 32 / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(MUL_ITERS);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_ITERS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4)) begin : g_bad_bpc
        $error("alu_mul_seq: BITS_PER_CYCLE must be 1, 2 or 4");
    end

    state_t            state, state_n;
    logic [DATA_W-1:0] acc, mcand, mplier, acc_n, mplier_sh, alu_res, data_q;
    logic [CNT_W-1:0]  cnt;
    logic              accept, is_mul, mul_last;

    assign bus.ready_o = state != MUL;
    assign bus.valid_o = state == DONE;
    assign bus.data_o  = data_q;
    assign accept      = bus.valid_i && bus.ready_o;
    assign is_mul      = bus.ALUCtrl_i == ALU_MUL;
    assign bus.stall_o = state == MUL || (accept && is_mul);
    assign mplier_sh   = mplier >> BITS_PER_CYCLE;
`ifdef ALU_MUL_EARLY_EXIT_EN
    assign mul_last    = cnt == '0 || mplier_sh == '0;
`else
    assign mul_last    = cnt == '0;
`endif

    alu_mul_step #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .slice    (mplier[BITS_PER_CYCLE-1:0]),
        .acc_next (acc_n)
    );

    always_comb begin
        alu_res = bus.ALUCtrl_i == ALU_AND ? bus.data1_i & bus.data2_i :
                  bus.ALUCtrl_i == ALU_OR  ? bus.data1_i | bus.data2_i :
                  bus.ALUCtrl_i == ALU_ADD ? bus.data1_i + bus.data2_i :
                  bus.ALUCtrl_i == ALU_SUB ? bus.data1_i - bus.data2_i : bus.data1_i;
        state_n = accept ? (is_mul ? MUL : DONE) :
                  state == DONE ? IDLE :
                  state == MUL && mul_last ? DONE : state;
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else       state <= state_n;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            data_q <= '0;
        end else if (accept && is_mul) begin
            acc    <= '0;
            mcand  <= bus.data1_i;
            mplier <= bus.data2_i;
            cnt    <= CNT_INIT;
        end else if (accept) begin
            data_q <= alu_res;
        end else if (state == MUL) begin
            acc    <= acc_n;
            mcand  <= mcand << BITS_PER_CYCLE;
            mplier <= mplier_sh;
            cnt    <= cnt - CNT_ONE;
            if (mul_last) data_q <= acc_n;
        end
endmodule
